// File: rtl/prince_mlayer_pipe.sv
// ============================================================================
// prince_mlayer_pipe
//   Pipelined, multi-lane PRINCE linear layer with valid/ready flow control.
//   Sits in the round datapath between the S-box and key-add stages.
//     mode 0 : M    = SR(M'(x))     (forward rounds)
//     mode 1 : M^-1 = M'(SR^-1(x))  (inverse rounds)
//   One beat carries LANES independent 64-bit states; all lanes share the
//   beat's mode and tag.
//
// Parameters
//   LANES   number of 64-bit states per beat (1..8)
//   STAGES  register stages, 1 or 2 (anything else stops elaboration)
//   TAG_W   width of the opaque sideband tag (>=1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle (combinational from out_ready)
//   in_mode    0 = M, 1 = M^-1, for every lane of the beat
//   in_data    lane l = in_data[64l+63:64l]
//   in_tag     sideband returned unchanged with the result
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   out_data   transformed lanes, same lane mapping as in_data
//   out_tag    tag of the beat currently on out_data
//   beat_cnt   (only with PRINCE_MLAYER_STATS_EN) saturating count of
//              output handshakes
//
// Build option
//   PRINCE_MLAYER_STATS_EN : adds the beat_cnt port and its counter. The
//   datapath is identical with or without it.
//
// Bit numbering: nibble n of a lane is bits [63-4n -: 4], nibble 0 is the
// most significant one. Chunk c is bits [63-16c -: 16] (nibbles 4c..4c+3).
// ============================================================================
module prince_mlayer_pipe #(
    parameter int LANES  = 1,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [64*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [64*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tag
`ifdef PRINCE_MLAYER_STATS_EN
    ,
    output logic [31:0]           beat_cnt
`endif
);

    // ShiftRows source-nibble tables, one nibble per entry, entry 0 in the
    // top nibble: SR picks out_nib[i] = in_nib[SR_TBL[i]], likewise SR^-1.
    localparam logic [63:0] SR_TBL  = 64'h05AF_49E3_8D27_C16B;
    localparam logic [63:0] SRI_TBL = 64'h0DA7_41EB_852F_C963;

    // Diagonal mask: all bits set except bit i (bit 0 = nibble MSB).
    function automatic logic [3:0] f_mask(input int i);
        return ~(4'b1000 >> i);
    endfunction

    // M' is block diagonal over the four 16-bit chunks. The outer chunks use
    // M^0 (rotation offset 0), the inner two use M^1 (offset 1). M' is its
    // own inverse, so both directions share it.
    function automatic logic [63:0] f_mp(input logic [63:0] x);
        logic [63:0] y;
        logic [3:0]  acc;
        int          s;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            s = (c == 1 || c == 2) ? 1 : 0;
            for (int r = 0; r < 4; r++) begin
                acc = 4'h0;
                for (int j = 0; j < 4; j++) begin
                    acc ^= x[63 - 16*c - 4*j -: 4] & f_mask((r + j + s) % 4);
                end
                y[63 - 16*c - 4*r -: 4] = acc;
            end
        end
        return y;
    endfunction

    // Nibble permutation driven by one of the tables above.
    function automatic logic [63:0] f_perm(input logic [63:0] x,
                                           input logic [63:0] tbl);
        logic [63:0] y;
        int          src;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            src = {28'd0, tbl[63 - 4*i -: 4]};
            y[63 - 4*i -: 4] = x[63 - 4*src -: 4];
        end
        return y;
    endfunction

    // ------------------------------------------------------------------
    // Per-lane datapath. Each lane has a "first" operation applied to the
    // incoming beat and a "second" operation applied to w_y. With one
    // stage w_y is the first result of the same beat (whole function in
    // one cycle); with two stages w_y is the stage-1 register.
    // ------------------------------------------------------------------
    logic [LANES-1:0][63:0] w_in;
    logic [LANES-1:0][63:0] w_first;
    logic [LANES-1:0][63:0] w_y;
    logic [LANES-1:0][63:0] w_second;
    logic                   w_ymode;

    assign w_in = in_data;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        // mode 0 starts with M', mode 1 starts with SR^-1
        assign w_first[l]  = in_mode ? f_perm(w_in[l], SRI_TBL) : f_mp(w_in[l]);
        // mode 0 finishes with SR, mode 1 finishes with M'
        assign w_second[l] = w_ymode ? f_mp(w_y[l]) : f_perm(w_y[l], SR_TBL);
    end

    // ------------------------------------------------------------------
    // Parameter guards
    // ------------------------------------------------------------------
    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
        $error("prince_mlayer_pipe: LANES must be in 1..8");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("prince_mlayer_pipe: TAG_W must be >= 1");
    end

    // ------------------------------------------------------------------
    // Pipeline registers and handshake
    // ------------------------------------------------------------------
    if (STAGES == 1) begin : g_s1
        logic                   r_v;
        logic [LANES-1:0][63:0] r_d;
        logic [TAG_W-1:0]       r_t;

        assign w_y      = w_first;
        assign w_ymode  = in_mode;
        // Output register is free when empty or being drained this cycle.
        assign in_ready = !r_v | out_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_d <= '0;
                r_t <= '0;
            end else if (in_ready) begin
                r_v <= in_valid;
                if (in_valid) begin
                    r_d <= w_second;
                    r_t <= in_tag;
                end
            end
        end

        assign out_valid = r_v;
        assign out_data  = r_d;
        assign out_tag   = r_t;
    end else if (STAGES == 2) begin : g_s2
        logic                   r_v1;
        logic                   r_m1;
        logic [LANES-1:0][63:0] r_d1;
        logic [TAG_W-1:0]       r_t1;
        logic                   r_v2;
        logic [LANES-1:0][63:0] r_d2;
        logic [TAG_W-1:0]       r_t2;
        logic                   w_ld2;
        logic                   w_adv1;

        // Stage 2 can take new content when empty or draining downstream.
        assign w_ld2    = !r_v2 | out_ready;
        // Stage 1 content moves on whenever stage 2 can take it.
        assign w_adv1   = r_v1 & w_ld2;
        assign in_ready = !r_v1 | w_adv1;

        assign w_y      = r_d1;
        assign w_ymode  = r_m1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v1 <= 1'b0;
                r_m1 <= 1'b0;
                r_d1 <= '0;
                r_t1 <= '0;
            end else if (in_ready) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_m1 <= in_mode;
                    r_d1 <= w_first;
                    r_t1 <= in_tag;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v2 <= 1'b0;
                r_d2 <= '0;
                r_t2 <= '0;
            end else if (w_ld2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_d2 <= w_second;
                    r_t2 <= r_t1;
                end
            end
        end

        assign out_valid = r_v2;
        assign out_data  = r_d2;
        assign out_tag   = r_t2;
    end else begin : g_bad_stages
        $error("prince_mlayer_pipe: STAGES must be 1 or 2");
    end

`ifdef PRINCE_MLAYER_STATS_EN
    // ------------------------------------------------------------------
    // Delivered-beat counter, sticks at all-ones.
    // ------------------------------------------------------------------
    logic [31:0] r_beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= 32'd0;
        end else if (out_valid && out_ready && (r_beat_cnt != 32'hFFFF_FFFF)) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

    assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_prince_mlayer_pipe.sv
// ============================================================================
// tb_prince_mlayer_pipe
//   Two instances: dut1 (LANES=1, STAGES=1) and dut2 (LANES=4, STAGES=2).
//   Accepted beats push their expected result into a per-DUT queue; a
//   monitor per DUT pops and compares on each output handshake, checks
//   latency where it is fixed, and checks output stability under stall.
//   Expected values are either literal constants or come from a bit-level
//   reference model of the linear layer.
// ============================================================================
module tb_prince_mlayer_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut1 signals
    logic          in1_valid, in1_ready, in1_mode, out1_valid, out1_ready;
    logic [63:0]   in1_data, out1_data;
    logic [3:0]    in1_tag, out1_tag;
    // dut2 signals
    logic          in2_valid, in2_ready, in2_mode, out2_valid, out2_ready;
    logic [255:0]  in2_data, out2_data;
    logic [3:0]    in2_tag, out2_tag;
`ifdef PRINCE_MLAYER_STATS_EN
    logic [31:0]   bc1, bc2;
`endif

    prince_mlayer_pipe #(.LANES(1), .STAGES(1), .TAG_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in1_valid), .in_ready(in1_ready), .in_mode(in1_mode),
        .in_data(in1_data), .in_tag(in1_tag),
        .out_valid(out1_valid), .out_ready(out1_ready),
        .out_data(out1_data), .out_tag(out1_tag)
`ifdef PRINCE_MLAYER_STATS_EN
        , .beat_cnt(bc1)
`endif
    );

    prince_mlayer_pipe #(.LANES(4), .STAGES(2), .TAG_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in2_valid), .in_ready(in2_ready), .in_mode(in2_mode),
        .in_data(in2_data), .in_tag(in2_tag),
        .out_valid(out2_valid), .out_ready(out2_ready),
        .out_data(out2_data), .out_tag(out2_tag)
`ifdef PRINCE_MLAYER_STATS_EN
        , .beat_cnt(bc2)
`endif
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int SRP [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    // M': output bit k of nibble r in a chunk is the XOR of bit k of every
    // input nibble j of that chunk, except the one where (r+j+s)%4 == k.
    function automatic logic [63:0] mdl_mp(input logic [63:0] x);
        logic [63:0] y;
        logic        b;
        int          s;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            s = (c == 1 || c == 2) ? 1 : 0;
            for (int r = 0; r < 4; r++) begin
                for (int k = 0; k < 4; k++) begin
                    b = 1'b0;
                    for (int j = 0; j < 4; j++)
                        if ((r + j + s) % 4 != k) b ^= x[63 - 4*(4*c + j) - k];
                    y[63 - 4*(4*c + r) - k] = b;
                end
            end
        end
        return y;
    endfunction

    function automatic logic [63:0] mdl_sr(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[63 - 4*i -: 4] = x[63 - 4*SRP[i] -: 4];
        return y;
    endfunction

    // Inverse ShiftRows as the scatter form of SR.
    function automatic logic [63:0] mdl_sri(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[63 - 4*SRP[i] -: 4] = x[63 - 4*i -: 4];
        return y;
    endfunction

    function automatic logic [63:0] mdl(input logic [63:0] x, input logic m);
        return m ? mdl_mp(mdl_sri(x)) : mdl_sr(mdl_mp(x));
    endfunction

    function automatic logic [255:0] mdl4(input logic [255:0] x, input logic m);
        logic [255:0] y;
        for (int l = 0; l < 4; l++) y[64*l +: 64] = mdl(x[64*l +: 64], m);
        return y;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard plumbing
    // ------------------------------------------------------------------
    typedef struct {
        logic [255:0] d;
        logic [3:0]   t;
        int           acc;
        bit           lat;
    } item_t;

    item_t q1[$];
    item_t q2[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    rdy1_pct = 100;
    int    rdy2_pct = 100;
    bit    lat2_en = 1'b0;
    int    stall2 = 0;
    int    n1_sent = 0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic send1(input logic m, input logic [63:0] d, input logic [63:0] e);
        item_t it;
        int    w = 0;
        bit    ok = 1'b1;
        in1_valid = 1'b1; in1_mode = m; in1_data = d; in1_tag = 4'($urandom);
        forever begin
            @(negedge clk);
            if (in1_ready) break;
            if (++w > 500) begin chk("send1_timeout", 1, 0); ok = 1'b0; break; end
        end
        if (ok) begin
            it.d = {192'd0, e}; it.t = in1_tag; it.acc = cyc; it.lat = 1'b1;
            q1.push_back(it);
            n1_sent++;
        end
        @(posedge clk); #1;
        in1_valid = 1'b0;
    endtask

    task automatic send2(input logic m, input logic [255:0] d, input logic [255:0] e);
        item_t it;
        int    w = 0;
        bit    ok = 1'b1;
        in2_valid = 1'b1; in2_mode = m; in2_data = d; in2_tag = 4'($urandom);
        forever begin
            @(negedge clk);
            if (in2_ready) break;
            stall2++;
            if (++w > 500) begin chk("send2_timeout", 1, 0); ok = 1'b0; break; end
        end
        if (ok) begin
            it.d = e; it.t = in2_tag; it.acc = cyc; it.lat = lat2_en;
            q2.push_back(it);
        end
        @(posedge clk); #1;
        in2_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((q1.size() != 0 || q2.size() != 0) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) chk("drain_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    // out_ready drivers
    initial begin
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out1_ready = (int'($urandom_range(99)) < rdy1_pct);
            out2_ready = (int'($urandom_range(99)) < rdy2_pct);
        end
    end

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    initial begin
        bit          pres = 1'b0, stl = 1'b0;
        logic [63:0] pd;
        logic [3:0]  pt;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pres = 1'b0; stl = 1'b0;
            end else begin
                if (stl) chk("dut1_hold", {out1_valid, out1_data, out1_tag}, {1'b1, pd, pt});
                if (out1_valid) begin
                    if (q1.size() == 0) begin
                        chk("dut1_unexpected", 1, 0);
                    end else begin
                        if (!pres && q1[0].lat) chk("dut1_latency", 256'(cyc - q1[0].acc), 1);
                        pres = 1'b1;
                        if (out1_ready) begin
                            chk("dut1_data", out1_data, q1[0].d);
                            chk("dut1_tag", out1_tag, q1[0].t);
                            void'(q1.pop_front());
                            pres = 1'b0;
                        end
                    end
                end
                stl = out1_valid & !out1_ready;
                pd = out1_data; pt = out1_tag;
            end
        end
    end

    initial begin
        bit           pres = 1'b0, stl = 1'b0;
        logic [255:0] pd;
        logic [3:0]   pt;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pres = 1'b0; stl = 1'b0;
            end else begin
                if (stl) chk("dut2_hold", {out2_valid, out2_data, out2_tag}, {1'b1, pd, pt});
                if (out2_valid) begin
                    if (q2.size() == 0) begin
                        chk("dut2_unexpected", 1, 0);
                    end else begin
                        if (!pres && q2[0].lat) chk("dut2_latency", 256'(cyc - q2[0].acc), 2);
                        pres = 1'b1;
                        if (out2_ready) begin
                            chk("dut2_data", out2_data, q2[0].d);
                            chk("dut2_tag", out2_tag, q2[0].t);
                            void'(q2.pop_front());
                            pres = 1'b0;
                        end
                    end
                end
                stl = out2_valid & !out2_ready;
                pd = out2_data; pt = out2_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [63:0]  x;
        logic [255:0] x4;
        logic         m;
        bit           quiet;

        in1_valid = 1'b0; in1_mode = 1'b0; in1_data = '0; in1_tag = '0;
        in2_valid = 1'b0; in2_mode = 1'b0; in2_data = '0; in2_tag = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ov1", out1_valid, 0);
        chk("rst_od1", out1_data, 0);
        chk("rst_ot1", out1_tag, 0);
        chk("rst_ov2", out2_valid, 0);
        chk("rst_od2", out2_data, 0);
        chk("rst_ot2", out2_tag, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy1", in1_ready, 1);
        chk("rst_rdy2", in2_ready, 1);
        @(posedge clk); #1;

        // Known vectors, single lane, single stage
        send1(1'b0, 64'h8000_0000_0000_0000, 64'h0000_0008_0080_0800);
        send1(1'b1, 64'h0000_0008_0080_0800, 64'h8000_0000_0000_0000);
        send1(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        send1(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        send1(1'b0, 64'h0, 64'h0);
        send1(1'b1, 64'h0, 64'h0);

        // Random single-lane traffic with backpressure and gaps
        rdy1_pct = 50;
        repeat (200) begin
            x = {$urandom, $urandom};
            m = 1'($urandom);
            send1(m, x, mdl(x, m));
            if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
        end

        // Four lanes: zero, all-ones, single MSB, random; mode 0
        x = {$urandom, $urandom};
        send2(1'b0, {x, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
              {mdl(x, 1'b0), 64'h0000_0008_0080_0800, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

        // Long random stream, two stages, 50% downstream readiness
        rdy2_pct = 50;
        repeat (1000) begin
            x4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom);
            send2(m, x4, mdl4(x4, m));
        end

        // Full-throughput stream: no input stalls, fixed 2-cycle latency
        rdy2_pct = 100;
        repeat (3) begin @(posedge clk); #1; end
        lat2_en = 1'b1;
        stall2 = 0;
        repeat (100) begin
            x4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom);
            send2(m, x4, mdl4(x4, m));
        end
        lat2_en = 1'b0;
        chk("thru_stalls", stall2, 0);

        rdy1_pct = 100;
        drain();
`ifdef PRINCE_MLAYER_STATS_EN
        chk("stats1_cnt", bc1, n1_sent);
`endif

        // Fill the two-stage pipe with downstream blocked, then reset
        rdy2_pct = 0;
        repeat (3) begin @(posedge clk); #1; end
        send2(1'b0, {4{64'h8000_0000_0000_0000}}, {4{64'h0000_0008_0080_0800}});
        send2(1'b1, {4{64'h1234_5678_9ABC_DEF0}}, mdl4({4{64'h1234_5678_9ABC_DEF0}}, 1'b1));
        in2_valid = 1'b1;
        @(negedge clk);
        chk("full_in_ready", in2_ready, 0);
        chk("full_out_valid", out2_valid, 1);
        #2;
        in2_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ov2", out2_valid, 0);
        chk("midrst_od2", out2_data, 0);
        chk("midrst_ot2", out2_tag, 0);
        q1.delete();
        q2.delete();
        rdy2_pct = 100;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_rdy2", in2_ready, 1);
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out2_valid) quiet = 1'b0;
        end
        chk("postrst_quiet", quiet, 1);
        @(posedge clk); #1;

`ifdef PRINCE_MLAYER_STATS_EN
        repeat (5) begin
            x4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send2(1'b0, x4, mdl4(x4, 1'b0));
        end
        drain();
        chk("stats2_five", bc2, 5);
        @(negedge clk);
        force dut2.r_beat_cnt = 32'hFFFF_FFFD;
        #1;
        release dut2.r_beat_cnt;
        @(posedge clk); #1;
        repeat (5) begin
            x4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send2(1'b1, x4, mdl4(x4, 1'b1));
        end
        drain();
        chk("stats2_sat", bc2, 32'hFFFF_FFFF);
`endif

        // Short mixed tail on both instances after reset
        rdy1_pct = 70;
        rdy2_pct = 70;
        repeat (20) begin
            x = {$urandom, $urandom};
            m = 1'($urandom);
            send1(m, x, mdl(x, m));
            x4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send2(~m, x4, mdl4(x4, ~m));
        end
        rdy1_pct = 100;
        rdy2_pct = 100;
        drain();
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
